// File: rtl/mmu_pkg.sv
// Shared definitions for the systolic matrix unit: element/vector widths,
// feeder state encoding and a small constant helper.
package mmu_pkg;

    localparam int ELEM_W    = 8;
    localparam int ARRAY_DIM = 3;
    localparam int VEC_W     = ELEM_W * ARRAY_DIM;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_CAPTURE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mmu_valid_delay.sv
// Single-bit delay line of DEPTH registers; dout is din delayed DEPTH cycles.
module mmu_valid_delay #(
    parameter int DEPTH = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else begin
            // The shift form also holds for DEPTH == 1, where a slice would not.
            shreg <= (shreg << 1) | DEPTH'(din);
        end
    end

    assign dout = shreg[DEPTH-1];

endmodule

// File: rtl/mmu_feeder.sv
// Input-side sequencer for the systolic array: loads weights, captures them,
// streams activations and marks the cycles where array psums are valid.
module mmu_feeder
    import mmu_pkg::*;
#(
    parameter int DATA_WIDTH = ELEM_W,
    parameter int ARRAY_SIZE = ARRAY_DIM,
    parameter int MAX_ROWS   = 16,
    parameter int PSUM_LAT   = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_load_w,
    input  logic [$clog2(MAX_ROWS+1)-1:0]    cmd_rows,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] w_data,
    input  logic                             a_valid,
    output logic                             a_ready,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] a_data,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] weight_data,
    output logic                             en_weight_pass,
    output logic                             en_capture_col0,
    output logic                             en_capture_col1,
    output logic                             en_capture_col2,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] act_data,
    output logic                             psum_valid,
    output logic                             busy,
    output logic                             done
);

    localparam int BEAT_W = $clog2(ARRAY_SIZE + 1);
    localparam int ROWS_W = $clog2(MAX_ROWS + 1);
    localparam int CNT_W  = $clog2(max_int(MAX_ROWS, PSUM_LAT + 1) + 1);

    localparam logic [ROWS_W-1:0] ROWS_CAP   = ROWS_W'(MAX_ROWS);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(ARRAY_SIZE - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(PSUM_LAT);

    feeder_state_e     state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [CNT_W-1:0]  rows_q;
    logic [CNT_W-1:0]  row_cnt;
    logic [CNT_W-1:0]  drain_cnt;
    logic [CNT_W-1:0]  rows_sat;
    logic              capture_q;
    logic              a_fire;

    assign cmd_ready = (state == ST_IDLE);
    assign w_ready   = (state == ST_LOAD_W);
    assign a_ready   = (state == ST_STREAM);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign a_fire    = a_valid && a_ready;
    assign rows_sat  = (cmd_rows > ROWS_CAP) ? CNT_W'(ROWS_CAP) : CNT_W'(cmd_rows);

    assign en_capture_col0 = capture_q;
    assign en_capture_col1 = capture_q;
    assign en_capture_col2 = capture_q;

    // NOTE: every register here, including the weight/activation data paths,
    // is reset so the array never sees stale values after an abandoned tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            beat_cnt       <= '0;
            rows_q         <= '0;
            row_cnt        <= '0;
            drain_cnt      <= '0;
            weight_data    <= '0;
            en_weight_pass <= 1'b0;
            capture_q      <= 1'b0;
            act_data       <= '0;
        end else begin
            // NOTE: non-blocking defaults make strobes single-cycle unless a
            // state below re-asserts them; later assignments win.
            en_weight_pass <= 1'b0;
            capture_q      <= 1'b0;
            act_data       <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        rows_q    <= rows_sat;
                        beat_cnt  <= '0;
                        row_cnt   <= '0;
                        drain_cnt <= '0;
                        if (cmd_load_w)          state <= ST_LOAD_W;
                        else if (rows_sat != '0) state <= ST_STREAM;
                        else                     state <= ST_DONE;
                    end
                end
                ST_LOAD_W: begin
                    if (w_valid) begin
                        weight_data    <= w_data;
                        en_weight_pass <= 1'b1;
                        beat_cnt       <= beat_cnt + BEAT_ONE;
                        if (beat_cnt == BEAT_LAST) state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    capture_q <= 1'b1;
                    state     <= (rows_q != '0) ? ST_STREAM : ST_DRAIN;
                end
                ST_STREAM: begin
                    if (a_valid) begin
                        act_data <= a_data;
                        row_cnt  <= row_cnt + CNT_ONE;
                        if (row_cnt + CNT_ONE == rows_q) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + CNT_ONE;
                    if (drain_cnt == DRAIN_LAST) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Accepted activation beats travel alongside the data through the array.
    mmu_valid_delay #(
        .DEPTH(PSUM_LAT + 1)
    ) u_psum_delay (
        .clk (clk),
        .rst (rst),
        .din (a_fire),
        .dout(psum_valid)
    );

endmodule

// File: tb/tb_mmu_feeder.sv
// Scoreboard bench for mmu_feeder: weight beats, activation beats and psum
// timing are predicted from the driven stimulus and compared as outputs appear.
module tb_mmu_feeder;
    import mmu_pkg::*;

    localparam int VW     = VEC_W;
    localparam int ROWS_W = $clog2(16 + 1);
    localparam int PLAT   = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0, cmd_ready, cmd_load_w = 1'b0;
    logic [ROWS_W-1:0] cmd_rows = '0;
    logic              w_valid = 1'b0, w_ready, a_valid = 1'b0, a_ready;
    logic [VW-1:0]     w_data = '0, a_data = '0, weight_data, act_data;
    logic              en_weight_pass, en_capture_col0, en_capture_col1, en_capture_col2;
    logic              psum_valid, busy, done;

    mmu_feeder dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load_w(cmd_load_w), .cmd_rows(cmd_rows),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .weight_data(weight_data), .en_weight_pass(en_weight_pass),
        .en_capture_col0(en_capture_col0), .en_capture_col1(en_capture_col1),
        .en_capture_col2(en_capture_col2),
        .act_data(act_data), .psum_valid(psum_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic [VW-1:0] wq[$];
    logic [VW-1:0] aq[$];
    int            pq[$];
    logic [VW-1:0] act_hist[int];
    logic          psum_hist[int];
    int pass_cnt = 0, cap_cnt = 0, done_cnt = 0, psum_cnt = 0, wr_cnt = 0, ar_cnt = 0;
    int last_pass_cyc = 0, first_pass_cyc = 0, cap_cyc = 0, last_psum_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard whenever the DUT produces something.
    always @(negedge clk) begin
        if (!rst) begin
            act_hist[cyc]  = act_data;
            psum_hist[cyc] = psum_valid;
            if (w_ready) wr_cnt++;
            if (a_ready) ar_cnt++;
            if (done) done_cnt++;
            if (en_weight_pass) begin
                if (pass_cnt == 0 || last_pass_cyc != cyc - 1) first_pass_cyc = cyc;
                pass_cnt++;
                last_pass_cyc = cyc;
                if (wq.size() == 0) check("weight_unexpected", 32'(1), 32'(0));
                else check("weight_data", 32'(weight_data), 32'(wq.pop_front()));
            end
            if (en_capture_col0 || en_capture_col1 || en_capture_col2) begin
                cap_cnt++;
                cap_cyc = cyc;
                check("capture_cols", {29'd0, en_capture_col0, en_capture_col1, en_capture_col2}, 32'd7);
                check("capture_no_pass", 32'(en_weight_pass), 32'(0));
            end
            if (act_data != '0) begin
                if (aq.size() == 0) check("act_unexpected", 32'(act_data), 32'(0));
                else check("act_data", 32'(act_data), 32'(aq.pop_front()));
            end
            if (psum_valid) begin
                psum_cnt++;
                last_psum_cyc = cyc;
                if (pq.size() == 0) check("psum_unexpected", 32'(cyc), 32'(0));
                else check("psum_cycle", 32'(cyc), 32'(pq.pop_front()));
            end
        end
    end

    task automatic send_cmd(input logic lw, input logic [ROWS_W-1:0] rows, output int acc);
        int n = 0;
        acc = -1;
        cmd_valid = 1'b1; cmd_load_w = lw; cmd_rows = rows;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (cmd_ready) acc = cyc + 1;
        else check("cmd_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_w(input logic [VW-1:0] d);
        int n = 0;
        w_valid = 1'b1; w_data = d;
        @(negedge clk);
        while (!w_ready && n < 50) begin @(negedge clk); n++; end
        if (w_ready) wq.push_back(d);
        else check("w_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic send_a(input logic [VW-1:0] d, output int acc);
        int n = 0;
        acc = -1;
        a_valid = 1'b1; a_data = d;
        @(negedge clk);
        while (!a_ready && n < 50) begin @(negedge clk); n++; end
        if (a_ready) begin
            acc = cyc + 1;
            aq.push_back(d);
            pq.push_back(acc + PLAT);
        end else check("a_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        dc = -1;
        @(negedge clk);
        while (!done && n < 200) begin @(negedge clk); n++; end
        if (done) begin
            dc = cyc;
            check("cmd_ready_in_done", 32'(cmd_ready), 32'(0));
        end else check("done_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_wq_empty"}, 32'(wq.size()), 32'(0));
        check({tag, "_aq_empty"}, 32'(aq.size()), 32'(0));
        check({tag, "_pq_empty"}, 32'(pq.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1, acc2, dc, d0, p0, pc0, wr0, ar0, cnt16;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ready", {30'd0, w_ready, a_ready}, 32'(0));
        check("rst_psum", 32'(psum_valid), 32'(0));
        check("rst_act", 32'(act_data), 32'(0));
        check("rst_weight", 32'(weight_data), 32'(0));
        @(posedge clk); #1;

        // Beats offered while idle are ignored
        w_valid = 1'b1; w_data = 24'hABCDEF;
        a_valid = 1'b1; a_data = 24'h123456;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_w_ready", 32'(w_ready), 32'(0));
            check("idle_a_ready", 32'(a_ready), 32'(0));
            check("idle_act", 32'(act_data), 32'(0));
            check("idle_pass", 32'(en_weight_pass), 32'(0));
        end
        @(posedge clk); #1;
        w_valid = 1'b0; a_valid = 1'b0;

        // Weight load, capture, two rows, drain
        p0 = pass_cnt;
        send_cmd(1'b1, ROWS_W'(2), acc);
        send_w(24'h030201);
        send_w(24'h060504);
        send_w(24'h090807);
        send_a(24'h112233, acc1);
        send_a(24'h445566, acc2);
        wait_done(dc);
        check("load_pass_count", 32'(pass_cnt - p0), 32'(3));
        check("load_pass_consecutive", 32'(last_pass_cyc - first_pass_cyc), 32'(2));
        check("load_capture_count", 32'(cap_cnt), 32'(1));
        check("load_capture_after_pass", 32'(cap_cyc > last_pass_cyc), 32'(1));
        check("load_done_cycle", 32'(dc), 32'(acc2 + PLAT + 1));
        check("load_done_after_psum", 32'(dc > last_psum_cyc), 32'(1));
        check_drained("load");

        // Reused weights, bubble between beats 1 and 2
        send_cmd(1'b0, ROWS_W'(3), acc);
        send_a(24'h010101, acc1);
        @(posedge clk); #1;
        send_a(24'h020202, acc);
        send_a(24'h030303, acc2);
        wait_done(dc);
        check("bubble_act_first", 32'(act_hist[acc1]), 32'h010101);
        check("bubble_act_zero", 32'(act_hist[acc1 + 1]), 32'(0));
        check("bubble_psum_pre", 32'(psum_hist[acc1 + PLAT - 1]), 32'(0));
        check("bubble_psum_pattern",
              {28'd0, psum_hist[acc1 + PLAT], psum_hist[acc1 + PLAT + 1],
               psum_hist[acc1 + PLAT + 2], psum_hist[acc1 + PLAT + 3]}, 32'b1011);
        check("bubble_capture_none", 32'(cap_cnt), 32'(1));
        check_drained("bubble");

        // Row count saturates at MAX_ROWS
        pc0 = psum_cnt;
        cnt16 = 0;
        send_cmd(1'b0, ROWS_W'(20), acc);
        for (int i = 0; i < 20; i++) begin
            a_valid = 1'b1;
            a_data = {3{8'(i + 1)}};
            @(negedge clk);
            if (a_ready) begin
                aq.push_back(a_data);
                pq.push_back(cyc + 1 + PLAT);
                cnt16++;
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        wait_done(dc);
        check("sat_accepts", 32'(cnt16), 32'(16));
        check("sat_psum_count", 32'(psum_cnt - pc0), 32'(16));
        check_drained("sat");

        // Zero rows, no weight load
        pc0 = psum_cnt; wr0 = wr_cnt; ar0 = ar_cnt;
        send_cmd(1'b0, ROWS_W'(0), acc);
        wait_done(dc);
        check("zero_done_cycle", 32'(dc), 32'(acc));
        check("zero_w_ready", 32'(wr_cnt - wr0), 32'(0));
        check("zero_a_ready", 32'(ar_cnt - ar0), 32'(0));
        check("zero_psum", 32'(psum_cnt - pc0), 32'(0));

        // Reset mid-stream abandons the tile
        send_cmd(1'b0, ROWS_W'(4), acc);
        send_a(24'h0A0B0C, acc1);
        send_a(24'h0D0E0F, acc2);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_psum", 32'(psum_valid), 32'(0));
        check("midrst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("midrst_act", 32'(act_data), 32'(0));
        aq.delete(); pq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        d0 = done_cnt; pc0 = psum_cnt;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done_cnt - d0), 32'(0));
        check("midrst_no_psum", 32'(psum_cnt - pc0), 32'(0));
        check("midrst_idle", 32'(busy), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
